// File: rtl/sparc_control_unit_pkg.sv
// Shared types and constants for the SPARC control sequencer: state encoding,
// ALU opcode constants, IR dispatch fields and the decoded control word.
package sparc_ctrl_pkg;

    typedef enum logic [3:0] {
        StReset = 4'd0,
        StInit,
        StF0,
        StF1,
        StDec,
        StAlu,
        StBr,
        StCall,
        StM0,
        StSt0,
        StSt1,
        StLd0,
        StLd1,
        StAdv,
        StHalt
    } state_e;

    localparam logic [5:0] OpAdd   = 6'h00;
    localparam logic [5:0] OpPassA = 6'h3E;
    localparam logic [5:0] OpPassB = 6'h3F;

    localparam int unsigned OpHi   = 31;
    localparam int unsigned OpLo   = 30;
    localparam int unsigned Op2Hi  = 24;
    localparam int unsigned Op2Lo  = 22;
    localparam int unsigned CcBit  = 23;
    localparam int unsigned StBit  = 21;
    localparam int unsigned SizeHi = 20;
    localparam int unsigned SizeLo = 19;
    localparam int unsigned ImmBit = 13;

    localparam logic [1:0] FmtBranch = 2'b00;
    localparam logic [1:0] FmtCall   = 2'b01;
    localparam logic [1:0] FmtAlu    = 2'b10;
    localparam logic [1:0] FmtMem    = 2'b11;
    localparam logic [2:0] Op2Bicc   = 3'b010;

    typedef struct packed {
        logic       register_windows_enable;
        logic       rf_load_enable;
        logic       rf_clear_enable;
        logic [4:0] clear_select;
        logic       ir_ld;
        logic       mar_ld;
        logic       mdr_ld;
        logic       wim_ld;
        logic       tbr_ld;
        logic       ttr_ld;
        logic       pc_ld;
        logic       npc_ld;
        logic       npc_clr;
        logic       psr_ld;
        logic       fr_ld;
        logic       rw;
        logic       mov;
        logic [1:0] size;
        logic [1:0] ma;
        logic [1:0] mb;
        logic [1:0] mnp;
        logic [1:0] mp;
        logic [1:0] msc;
        logic       mc;
        logic       mf;
        logic       mm;
        logic       mop;
        logic       msa;
        logic [5:0] opxx;
    } ctrl_word_t;

    function automatic logic is_wait_state(state_e s);
        return (s == StF1) || (s == StSt1) || (s == StLd0);
    endfunction

endpackage

// File: rtl/sparc_control_unit_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface sparc_control_unit_if;
    logic [31:0] IR;
    logic        MOC, BCOND, TCOND;
    logic        Register_Windows_Enable, RF_Load_Enable, RF_Clear_Enable;
    logic [4:0]  Clear_Select;
    logic        IR_Ld, MAR_Ld, MDR_Ld, WIM_Ld, TBR_Ld, TTR_Ld, PC_Ld, NPC_Ld, nPC_Clr;
    logic        PSR_Ld, FR_Ld, RW, MOV;
    logic [1:0]  Type;
    logic [1:0]  MA, MB, MNP, MP, MSc;
    logic        MC, MF, MM, MOP, MSa;
    logic [5:0]  OpXX;
    logic        Mem_Fault;

    modport master (
        input  IR, MOC, BCOND, TCOND,
        output Register_Windows_Enable, RF_Load_Enable, RF_Clear_Enable, Clear_Select,
        output IR_Ld, MAR_Ld, MDR_Ld, WIM_Ld, TBR_Ld, TTR_Ld, PC_Ld, NPC_Ld, nPC_Clr,
        output PSR_Ld, FR_Ld, RW, MOV, Type, MA, MB, MNP, MP, MSc,
        output MC, MF, MM, MOP, MSa, OpXX, Mem_Fault
    );

    modport slave (
        output IR, MOC, BCOND, TCOND,
        input  Register_Windows_Enable, RF_Load_Enable, RF_Clear_Enable, Clear_Select,
        input  IR_Ld, MAR_Ld, MDR_Ld, WIM_Ld, TBR_Ld, TTR_Ld, PC_Ld, NPC_Ld, nPC_Clr,
        input  PSR_Ld, FR_Ld, RW, MOV, Type, MA, MB, MNP, MP, MSc,
        input  MC, MF, MM, MOP, MSa, OpXX, Mem_Fault
    );
endinterface

// File: rtl/sparc_control_unit_ctrl_word_decode.sv
// Combinational Moore decode: current state plus IR to the datapath control word.
module ctrl_word_decode
    import sparc_ctrl_pkg::*;
(
    input  state_e      state_i,
    input  logic [31:0] ir_i,
    input  logic        bcond_i,
    output ctrl_word_t  cw_o
);

    logic [1:0] op2_sel;
    logic       unused_ir;

    assign op2_sel   = ir_i[ImmBit] ? 2'b01 : 2'b00;
    assign unused_ir = ^ir_i;

    always_comb begin
        cw_o = '0;
        unique case (state_i)
            StReset: begin
                cw_o.npc_clr         = 1'b1;
                cw_o.pc_ld           = 1'b1;
                cw_o.mp              = 2'b00;
                cw_o.rf_clear_enable = 1'b1;
            end
            StInit: begin
                cw_o.mnp    = 2'b11;
                cw_o.npc_ld = 1'b1;
            end
            StF0: begin
                cw_o.mb     = 2'b10;
                cw_o.mop    = 1'b1;
                cw_o.opxx   = OpPassB;
                cw_o.mar_ld = 1'b1;
            end
            StF1: begin
                cw_o.mov   = 1'b1;
                cw_o.rw    = 1'b1;
                cw_o.ir_ld = 1'b1;
            end
            StAlu: begin
                cw_o.register_windows_enable = 1'b1;
                cw_o.rf_load_enable          = 1'b1;
                cw_o.mb                      = op2_sel;
                cw_o.fr_ld                   = ir_i[CcBit];
            end
            StCall: begin
                // Link write of r15 and the PC/nPC redirect share one edge.
                cw_o.rf_load_enable = 1'b1;
                cw_o.msc            = 2'b01;
                cw_o.mb             = 2'b10;
                cw_o.mop            = 1'b1;
                cw_o.opxx           = OpPassB;
                cw_o.mp             = 2'b11;
                cw_o.mnp            = 2'b10;
                cw_o.pc_ld          = 1'b1;
                cw_o.npc_ld         = 1'b1;
            end
            StM0: begin
                cw_o.mb     = op2_sel;
                cw_o.mop    = 1'b1;
                cw_o.opxx   = OpAdd;
                cw_o.mar_ld = 1'b1;
            end
            StSt0: begin
                cw_o.msa    = 1'b1;
                cw_o.mop    = 1'b1;
                cw_o.opxx   = OpPassA;
                cw_o.mm     = 1'b1;
                cw_o.mdr_ld = 1'b1;
            end
            StSt1: begin
                cw_o.mov  = 1'b1;
                cw_o.size = ir_i[SizeHi:SizeLo];
            end
            StLd0: begin
                cw_o.mov    = 1'b1;
                cw_o.rw     = 1'b1;
                cw_o.size   = ir_i[SizeHi:SizeLo];
                cw_o.mdr_ld = 1'b1;
            end
            StLd1: begin
                cw_o.mb             = 2'b11;
                cw_o.mop            = 1'b1;
                cw_o.opxx           = OpPassB;
                cw_o.rf_load_enable = 1'b1;
            end
            StBr, StAdv: begin
                // An untaken branch advances sequentially, exactly like StAdv.
                cw_o.mp     = 2'b11;
                cw_o.mnp    = (state_i == StBr && bcond_i) ? 2'b10 : 2'b11;
                cw_o.pc_ld  = 1'b1;
                cw_o.npc_ld = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sparc_control_unit.sv
// SPARC V8 subset sequencer: state register, memory wait counter and sticky fault flag.
module sparc_control_unit
    import sparc_ctrl_pkg::*;
#(
    parameter int unsigned MOC_TIMEOUT = 16
) (
    input  logic                        Clk,
    input  logic                        Clr_n,
    sparc_control_unit_if.master        bus
);

    localparam logic [3:0] TimeoutCnt = 4'(MOC_TIMEOUT - 1);

    state_e     state_q, state_d, moc_next, dec_state;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_fault_q, mem_fault_d;
    ctrl_word_t cw;
    logic       unused_tcond;

    assign unused_tcond = bus.TCOND;
    // Reset outputs show immediately while Clr_n is low, not only after the first edge.
    assign dec_state    = Clr_n ? state_q : StReset;
    assign moc_next     = (state_q == StF1) ? StDec : (state_q == StSt1) ? StAdv : StLd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = 4'd0;
        mem_fault_d = mem_fault_q;
        if (is_wait_state(state_q)) begin
            if (bus.MOC) begin
                state_d = moc_next;
            end else if (cnt_q == TimeoutCnt) begin
                state_d     = StHalt;
                mem_fault_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            unique case (state_q)
                StReset: state_d = StInit;
                StInit:  state_d = StF0;
                StF0:    state_d = StF1;
                StDec: begin
                    if (bus.IR[OpHi:OpLo] == FmtCall) begin
                        state_d = StCall;
                    end else if (bus.IR[OpHi:OpLo] == FmtBranch &&
                                 bus.IR[Op2Hi:Op2Lo] == Op2Bicc) begin
                        state_d = StBr;
                    end else if (bus.IR[OpHi:OpLo] == FmtAlu) begin
                        state_d = StAlu;
                    end else if (bus.IR[OpHi:OpLo] == FmtMem) begin
                        state_d = StM0;
                    end else begin
                        state_d = StAdv;
                    end
                end
                StAlu:   state_d = StAdv;
                StBr:    state_d = StF0;
                StCall:  state_d = StF0;
                StM0:    state_d = bus.IR[StBit] ? StSt0 : StLd0;
                StSt0:   state_d = StSt1;
                StLd1:   state_d = StAdv;
                StAdv:   state_d = StF0;
                StHalt:  state_d = StHalt;
                default: state_d = StHalt;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            state_q     <= StReset;
            cnt_q       <= 4'd0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    ctrl_word_decode u_decode (
        .state_i (dec_state),
        .ir_i    (bus.IR),
        .bcond_i (bus.BCOND),
        .cw_o    (cw)
    );

    assign bus.Register_Windows_Enable = cw.register_windows_enable;
    assign bus.RF_Load_Enable          = cw.rf_load_enable;
    assign bus.RF_Clear_Enable         = cw.rf_clear_enable;
    assign bus.Clear_Select            = cw.clear_select;
    assign bus.IR_Ld                   = cw.ir_ld;
    assign bus.MAR_Ld                  = cw.mar_ld;
    assign bus.MDR_Ld                  = cw.mdr_ld;
    assign bus.WIM_Ld                  = cw.wim_ld;
    assign bus.TBR_Ld                  = cw.tbr_ld;
    assign bus.TTR_Ld                  = cw.ttr_ld;
    assign bus.PC_Ld                   = cw.pc_ld;
    assign bus.NPC_Ld                  = cw.npc_ld;
    assign bus.nPC_Clr                 = cw.npc_clr;
    assign bus.PSR_Ld                  = cw.psr_ld;
    assign bus.FR_Ld                   = cw.fr_ld;
    assign bus.RW                      = cw.rw;
    assign bus.MOV                     = cw.mov;
    assign bus.Type                    = cw.size;
    assign bus.MA                      = cw.ma;
    assign bus.MB                      = cw.mb;
    assign bus.MNP                     = cw.mnp;
    assign bus.MP                      = cw.mp;
    assign bus.MSc                     = cw.msc;
    assign bus.MC                      = cw.mc;
    assign bus.MF                      = cw.mf;
    assign bus.MM                      = cw.mm;
    assign bus.MOP                     = cw.mop;
    assign bus.MSa                     = cw.msa;
    assign bus.OpXX                    = cw.opxx;
    assign bus.Mem_Fault               = mem_fault_q;

endmodule

// File: tb/tb_sparc_control_unit.sv
// Directed bench for sparc_control_unit: walks fetch, ALU, load, store, branch, call
// and memory-timeout sequences against hand-computed control values.
module tb_sparc_control_unit;

    logic clk;
    logic clr_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    sparc_control_unit_if bus ();

    sparc_control_unit #(
        .MOC_TIMEOUT (16)
    ) dut (
        .Clk   (clk),
        .Clr_n (clr_n),
        .bus   (bus)
    );

    logic [43:0] ctl_vec;
    assign ctl_vec = {bus.Register_Windows_Enable, bus.RF_Load_Enable, bus.RF_Clear_Enable,
                      bus.Clear_Select, bus.IR_Ld, bus.MAR_Ld, bus.MDR_Ld, bus.WIM_Ld,
                      bus.TBR_Ld, bus.TTR_Ld, bus.PC_Ld, bus.NPC_Ld, bus.nPC_Clr, bus.PSR_Ld,
                      bus.FR_Ld, bus.RW, bus.MOV, bus.Type, bus.MA, bus.MB, bus.MNP, bus.MP,
                      bus.MSc, bus.MC, bus.MF, bus.MM, bus.MOP, bus.MSa, bus.OpXX};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clr_n     = 1'b0;
        bus.IR    = 32'h0;
        bus.MOC   = 1'b0;
        bus.BCOND = 1'b0;
        bus.TCOND = 1'b0;

        // Reset held two cycles
        #1;
        chk("reset_comb_pc_ld", bus.PC_Ld, 1);
        tick();
        tick();
        chk("reset_pc_ld", bus.PC_Ld, 1);
        chk("reset_npc_clr", bus.nPC_Clr, 1);
        chk("reset_mp", bus.MP, 0);
        chk("reset_rf_clear", bus.RF_Clear_Enable, 1);
        chk("reset_fault", bus.Mem_Fault, 0);
        clr_n = 1'b1;
        tick();
        chk("init_npc", {bus.NPC_Ld, bus.MNP}, 3'b111);
        tick();
        chk("f0_mar", {bus.MAR_Ld, bus.MB, bus.MOP}, 4'b1101);
        chk("f0_opxx", bus.OpXX, 6'h3F);

        // Fetch stall: MOC low for 3 cycles, high on the 4th
        bus.IR = 32'h86004002;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.MOC = 1'b1;
            chk($sformatf("f1_stall_%0d", i), {bus.MOV, bus.RW, bus.IR_Ld}, 3'b111);
            tick();
        end
        bus.MOC = 1'b0;
        chk("dec_idle", ctl_vec, 0);
        tick();
        chk("alu_mb", bus.MB, 0);
        chk("alu_rf_ld", {bus.Register_Windows_Enable, bus.RF_Load_Enable}, 2'b11);
        chk("alu_fr_ld", bus.FR_Ld, 0);
        tick();
        chk("adv_mux", {bus.MP, bus.MNP}, 4'hF);
        chk("adv_ld", {bus.PC_Ld, bus.NPC_Ld}, 2'b11);
        tick();
        chk("alu_back_f0", bus.MAR_Ld, 1);

        // Load word: ld [r1+4],r1
        bus.IR = 32'hC2006004;
        tick();
        bus.MOC = 1'b1;
        tick();
        bus.MOC = 1'b0;
        tick();
        chk("ld_m0", {bus.MB, bus.MAR_Ld, bus.MOP}, 4'b0111);
        chk("ld_m0_op", bus.OpXX, 6'h00);
        tick();
        chk("ld0", {bus.MOV, bus.RW, bus.Type, bus.MDR_Ld}, 5'b11001);
        bus.MOC = 1'b1;
        tick();
        bus.MOC = 1'b0;
        chk("ld1", {bus.MB, bus.RF_Load_Enable}, 3'b111);
        tick();
        chk("ld_adv", bus.PC_Ld, 1);
        tick();

        // Store halfword: sth r2,[r1+8]
        bus.IR = 32'hC4306008;
        tick();
        bus.MOC = 1'b1;
        tick();
        bus.MOC = 1'b0;
        tick();
        tick();
        chk("st0", {bus.MSa, bus.MM, bus.MDR_Ld}, 3'b111);
        chk("st0_op", bus.OpXX, 6'h3E);
        tick();
        chk("st1_a", {bus.MOV, bus.RW, bus.Type}, 4'b1010);
        tick();
        chk("st1_b", {bus.MOV, bus.RW, bus.Type}, 4'b1010);
        bus.MOC = 1'b1;
        tick();
        bus.MOC = 1'b0;
        chk("st_adv", {bus.MP, bus.MNP}, 4'hF);
        tick();

        // Branch taken
        bus.IR    = 32'h10800004;
        bus.BCOND = 1'b1;
        tick();
        bus.MOC = 1'b1;
        tick();
        bus.MOC = 1'b0;
        tick();
        chk("br_taken", {bus.MP, bus.MNP, bus.PC_Ld, bus.NPC_Ld}, 6'b111011);
        tick();
        chk("br_taken_f0", bus.MAR_Ld, 1);

        // Branch not taken
        bus.BCOND = 1'b0;
        tick();
        bus.MOC = 1'b1;
        tick();
        bus.MOC = 1'b0;
        tick();
        chk("br_untaken", {bus.MP, bus.MNP, bus.PC_Ld, bus.NPC_Ld}, 6'b111111);
        tick();
        chk("br_untaken_f0", bus.MAR_Ld, 1);

        // Call
        bus.IR = 32'h40000010;
        tick();
        bus.MOC = 1'b1;
        tick();
        bus.MOC = 1'b0;
        tick();
        chk("call", {bus.MSc, bus.RF_Load_Enable, bus.MNP, bus.MP}, 7'b0111011);
        chk("call_op", bus.OpXX, 6'h3F);
        tick();

        // MOC never returns: halt after 16 wait cycles
        tick();
        repeat (15) tick();
        chk("to_last_wait", {bus.IR_Ld, bus.Mem_Fault}, 2'b10);
        tick();
        chk("to_fault", bus.Mem_Fault, 1);
        chk("to_halt_out", ctl_vec, 0);
        tick();
        tick();
        chk("halt_stays", {ctl_vec, bus.Mem_Fault}, 45'h1);
        clr_n = 1'b0;
        #1;
        chk("halt_reset_comb", bus.PC_Ld, 1);
        tick();
        chk("fault_cleared", bus.Mem_Fault, 0);
        clr_n = 1'b1;
        tick();
        chk("restart_init", {bus.NPC_Ld, bus.MNP}, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sparc_control_unit.md
# sparc_control_unit

Hardwired sequencer that drives every control input of the SPARC datapath: fetch, decode, execute, and PC/nPC update for a subset of SPARC V8. It sits directly upstream of the datapath. It consumes the datapath's `IR`, `MOC`, `BCOND` and `TCOND` and produces its load enables and mux selects. Outputs are a Moore decode of a registered state plus the current IR.

## Interface
Parameters:
- `MOC_TIMEOUT`, 16: maximum cycles spent waiting for `MOC` before fault.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Clr_n`  in  1  synchronous active-low reset.
- `IR`  in  32  datapath instruction register.
- `MOC`, `BCOND`, `TCOND`  in  1 each  memory-operation-complete, branch condition true, trap condition true.
- `Register_Windows_Enable`, `RF_Load_Enable`, `RF_Clear_Enable`  out  1 each.
- `Clear_Select`  out  5.
- `IR_Ld`, `MAR_Ld`, `MDR_Ld`, `WIM_Ld`, `TBR_Ld`, `TTR_Ld`, `PC_Ld`, `NPC_Ld`, `nPC_Clr`, `PSR_Ld`, `FR_Ld`, `RW`, `MOV`  out  1 each.
- `type`  out  2  memory access size.
- `MA`, `MB`, `MNP`, `MP`, `MSc`  out  2 each.
- `MC`, `MF`, `MM`, `MOP`, `MSa`  out  1 each.
- `OpXX`  out  6  ALU opcode used when `MOP`=1.
- `Mem_Fault`  out  1  sticky; set on a `MOC` timeout.

## Operation
- Default for every output in every state is 0 unless listed below. `OpXX` constants: `OP_ADD`=6'h00, `OP_PASS_A`=6'h3E, `OP_PASS_B`=6'h3F.
- S_RESET: `nPC_Clr`=1, `PC_Ld`=1, `MP`=00 (PC←0), `RF_Clear_Enable`=1. Next: S_INIT.
- S_INIT: NPC←NPC+4 (`MNP`=11, `NPC_Ld`). Next: S_F0.
- S_F0: MAR←PC (`MC`=0, `MB`=10, `MOP`=1, `OpXX`=PASS_B, `MAR_Ld`). Next: S_F1.
- S_F1: `MOV`=1, `RW`=1, `type`=00, `IR_Ld`=1. Stays in S_F1 until `MOC`=1, then S_DEC.
- S_DEC: no enables. Dispatch on `IR[31:30]`:
  - 01 → S_CALL.
  - 00 with `IR[24:22]`=010 → S_BR.
  - 10 → S_ALU.
  - 11 → S_M0.
  - anything else → S_ADV.
- S_ALU: `Register_Windows_Enable`, `RF_Load_Enable`, `MSa`=0, `MSc`=00, `MA`=00, `MB`=`IR[13]`?01:00, `MOP`=0, `FR_Ld`=`IR[23]`. Next: S_ADV.
- S_BR, when `BCOND`=1: PC←NPC (`MP`=11), NPC←PC+disp (`MNP`=10), both loaded. Next: S_F0.
- S_BR, when `BCOND`=0: behaves exactly as S_ADV.
- S_CALL: r15←PC (`MSc`=01, `MC`=0, `MB`=10, PASS_B, RF load). Same edge: PC←NPC, NPC←PC+disp. Next: S_F0.
- S_M0: MAR←rs1+op2 (`MSa`=0, `MA`=00, `MB` as S_ALU, `OpXX`=ADD, `MAR_Ld`). Next: S_ST0 if `IR[21]`=1, else S_LD0.
- S_ST0: MDR←rd (`MSa`=1, PASS_A, `MM`=1, `MDR_Ld`). Next: S_ST1.
- S_ST1: `MOV`=1, `RW`=0, `type`=`IR[20:19]`. Waits for `MOC`, then S_ADV.
- S_LD0: `MOV`=1, `RW`=1, `type`=`IR[20:19]`, `MM`=0, `MDR_Ld`=1. Waits for `MOC`, then S_LD1.
- S_LD1: rd←MDR (`MB`=11, PASS_B, RF load). Next: S_ADV.
- S_ADV: PC←NPC (`MP`=11), NPC←NPC+4 (`MNP`=11). Next: S_F0.
- S_HALT: all outputs 0. Left only by reset.

## Timing
- Reset: `Clr_n` sampled low at a rising edge puts the state in S_RESET and clears `Mem_Fault` and the wait counter. This applies in any state, including mid memory wait.
- While `Clr_n`=0, the S_RESET outputs are asserted.
- Throughput, with `MOC` returned in its first wait cycle:
  - ALU instruction: 5 cycles (F0, F1, DEC, ALU, ADV).
  - Load: 7 cycles.
  - Store: 7 cycles.
  - Taken branch: 4 cycles.
- Wait states (S_F1, S_ST1, S_LD0):
  - A 4-bit counter starts at 0 on entry and increments each cycle that `MOC`=0.
  - When the counter reaches `MOC_TIMEOUT`-1 with `MOC`=0, the next state is S_HALT and `Mem_Fault` is set.
  - `MOC`=1 in the same cycle as the counter reaching that value takes priority: normal transition.
- Load enables are held the whole wait. The datapath loads on the `MOC` edge; earlier loads of not-ready data are overwritten.
- `TCOND` is unused by this revision. Traps are a later extension.

## Structure
- Package `sparc_ctrl_pkg` holds:
  - the state enum (4-bit encoding, S_RESET=0);
  - the `OpXX` constants;
  - the dispatch field positions.
- Sub-module `ctrl_word_decode`: combinational state+IR → control outputs.
- The top level holds the state register, the wait counter and `Mem_Fault`.

## Test plan
- Reset: hold `Clr_n`=0 for 2 cycles → `PC_Ld`=1, `nPC_Clr`=1, `MP`=00. After release, the next two states are S_INIT then S_F0, with `MAR_Ld`=1 and `MB`=10.
- Fetch stall: `MOC` low for 3 cycles in S_F1 → `MOV`=`RW`=`IR_Ld`=1 for 4 cycles, then S_DEC.
- IR=0x86004002 (add r3,r1,r2) → S_ALU: `MB`=00, `RF_Load_Enable`=1, `FR_Ld`=0. Next cycle `MP`=11, `MNP`=11.
- IR=0xC2006004 (ld [r1+4],r1) → S_M0 with `MB`=01 and `OpXX`=0; then S_LD0 with `RW`=1, `type`=00; then S_LD1 with `MB`=11.
- Bicc with `BCOND`=1 → `MNP`=10, `MP`=11 in one cycle, then S_F0. With `BCOND`=0 → `MNP`=11.
- `MOC` never asserted in S_F1 → after 16 cycles the state is S_HALT and `Mem_Fault`=1. A following `Clr_n` pulse clears both.
